// File: rtl/hamming_enc_seq.sv
// Memory-port sequencer: reads NUM_MSG 11-bit messages, computes their SEC-DED (16,11)
// codewords and writes them back, arbitrated by a dm_req/dm_gnt handshake.
module hamming_enc_seq #(
  parameter int NUM_MSG  = 15,
  parameter int SRC_BASE = 0,
  parameter int DST_BASE = 30,
  parameter int AW       = 8
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          req,
  output logic          ack,
  output logic          busy,
  output logic          dm_req,
  input  logic          dm_gnt,
  output logic [AW-1:0] mem_addr,
  output logic          mem_wr_en,
  output logic [7:0]    mem_wr_data,
  input  logic [7:0]    mem_rd_data
);

  localparam int IW = $clog2(NUM_MSG + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_RD_LO, S_RD_HI, S_CAP, S_WR_LO, S_WR_HI, S_DONE
  } state_t;

  state_t          state, state_nx;
  logic [IW-1:0]   idx, idx_nx;
  logic            req_d;
  logic            rd_pend, rd_sel_hi;
  logic [7:0]      lo_q;
  logic [2:0]      hi_q;

  logic            start, last;
  logic [AW-1:0]   ofs, src_lo, dst_lo;
  logic [11:1]     d;
  logic            p8, p4, p2, p1, p0;
  logic [15:0]     cw;

  assign start  = (state == S_IDLE) && req && !req_d;
  assign last   = (idx == IW'(NUM_MSG - 1));
  // Byte offsets wrap in AW bits by construction.
  assign ofs    = AW'({idx, 1'b0});
  assign src_lo = AW'(SRC_BASE) + ofs;
  assign dst_lo = AW'(DST_BASE) + ofs;

  assign d  = {hi_q, lo_q};
  assign p8 = ^d[11:5];
  assign p4 = (^d[11:8]) ^ (^d[4:2]);
  assign p2 = d[11] ^ d[10] ^ d[7] ^ d[6] ^ d[4] ^ d[3] ^ d[1];
  assign p1 = d[11] ^ d[9]  ^ d[7] ^ d[5] ^ d[4] ^ d[2] ^ d[1];
  assign p0 = (^d) ^ p8 ^ p4 ^ p2 ^ p1;
  assign cw = {d[11:5], p8, d[4:2], p4, d[1], p2, p1, p0};

  // NOTE: non-blocking assignments for all state so every register samples pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      idx       <= '0;
      req_d     <= 1'b0;
      rd_pend   <= 1'b0;
      rd_sel_hi <= 1'b0;
      lo_q      <= '0;
      hi_q      <= '0;
    end else begin
      state     <= state_nx;
      idx       <= idx_nx;
      req_d     <= req;
      rd_pend   <= dm_req && dm_gnt && (state == S_RD_LO || state == S_RD_HI);
      rd_sel_hi <= (state == S_RD_HI);
      // Read data arrives one cycle after the grant, whatever the FSM is doing then.
      if (rd_pend) begin
        if (rd_sel_hi) hi_q <= mem_rd_data[2:0];
        else           lo_q <= mem_rd_data;
      end
    end
  end

  // NOTE: every output of this block gets a default first, so no latch is inferred.
  always_comb begin
    state_nx    = state;
    idx_nx      = idx;
    dm_req      = 1'b0;
    mem_addr    = '0;
    mem_wr_en   = 1'b0;
    mem_wr_data = '0;
    ack         = 1'b0;
    busy        = (state != S_IDLE);
    unique case (state)
      S_IDLE: begin
        if (start) begin
          busy     = 1'b1;
          idx_nx   = '0;
          state_nx = S_RD_LO;
        end
      end
      S_RD_LO: begin
        dm_req   = 1'b1;
        mem_addr = src_lo;
        if (dm_gnt) state_nx = S_RD_HI;
      end
      S_RD_HI: begin
        dm_req   = 1'b1;
        mem_addr = src_lo + AW'(1);
        if (dm_gnt) state_nx = S_CAP;
      end
      S_CAP: state_nx = S_WR_LO;
      S_WR_LO: begin
        dm_req      = 1'b1;
        mem_addr    = dst_lo;
        mem_wr_data = cw[7:0];
        mem_wr_en   = dm_gnt;
        if (dm_gnt) state_nx = S_WR_HI;
      end
      S_WR_HI: begin
        dm_req      = 1'b1;
        mem_addr    = dst_lo + AW'(1);
        mem_wr_data = cw[15:8];
        mem_wr_en   = dm_gnt;
        if (dm_gnt) begin
          if (last) begin
            state_nx = S_DONE;
          end else begin
            idx_nx   = idx + IW'(1);
            state_nx = S_RD_LO;
          end
        end
      end
      S_DONE: begin
        ack      = 1'b1;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_hamming_enc_seq.sv
// Self-checking bench for hamming_enc_seq: byte memory model, positional Hamming
// reference, directed vector table plus randomized runs and handshake corner cases.
module tb_hamming_enc_seq;

  localparam int NUM_MSG = 15;
  localparam int SRC     = 0;
  localparam int DST     = 30;

  logic       clock = 1'b0;
  logic       reset;
  logic       req;
  logic       ack, busy, dm_req, dm_gnt, mem_wr_en;
  logic [7:0] mem_addr, mem_wr_data, mem_rd_data;

  hamming_enc_seq #(.NUM_MSG(NUM_MSG), .SRC_BASE(SRC), .DST_BASE(DST), .AW(8)) dut (
    .clock(clock), .reset(reset), .req(req), .ack(ack), .busy(busy),
    .dm_req(dm_req), .dm_gnt(dm_gnt), .mem_addr(mem_addr), .mem_wr_en(mem_wr_en),
    .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data)
  );

  always #5 clock = ~clock;

  // Memory model: source image loaded by the test, written bytes tagged by run id.
  logic [7:0] src_img [256];
  logic [7:0] wmem    [256];
  int         wr_gen  [256];
  int         run_id = 0;
  int n_wr = 0, n_badwr = 0, n_denied = 0, n_ack = 0, n_busy = 0;
  bit gnt_random = 1'b0;

  always @(posedge clock) begin
    if (mem_wr_en) begin
      wmem[mem_addr]   <= mem_wr_data;
      wr_gen[mem_addr] <= run_id;
      n_wr             <= n_wr + 1;
      if (!dm_gnt) n_badwr <= n_badwr + 1;
    end
    if (dm_req && !dm_gnt) n_denied <= n_denied + 1;
    if (ack)  n_ack  <= n_ack + 1;
    if (busy) n_busy <= n_busy + 1;
    mem_rd_data <= (dm_req && dm_gnt && !mem_wr_en) ? src_img[mem_addr] : 8'($urandom);
  end

  initial begin
    dm_gnt = 1'b1;
    forever begin
      @(negedge clock);
      dm_gnt = gnt_random ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  int n_chk = 0, n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else n_pass++;
  endtask

  // Reference: classic positional Hamming(15,11) plus overall parity at bit 0.
  function automatic logic [15:0] ref_cw(input logic [7:0] lo, input logic [7:0] hi);
    logic [10:0] dd;
    logic [15:0] c;
    int k;
    dd = {hi[2:0], lo};
    c  = '0;
    k  = 0;
    for (int pos = 1; pos < 16; pos++)
      if ((pos & (pos - 1)) != 0) begin
        c[pos] = dd[k];
        k++;
      end
    for (int b = 0; b < 4; b++) begin
      int  j;
      logic p;
      j = 1 << b;
      p = 1'b0;
      for (int pos = 1; pos < 16; pos++)
        if ((pos & j) != 0) p ^= c[pos];
      c[j] = p;
    end
    c[0] = ^c[15:1];
    return c;
  endfunction

  function automatic logic [7:0] dst_byte(input int a);
    return (wr_gen[a] == run_id) ? wmem[a] : 8'hxx;
  endfunction

  task automatic load_random();
    for (int i = 0; i < 2 * NUM_MSG; i++) src_img[SRC + i] = 8'($urandom);
  endtask

  task automatic verify_image(input string tag, input int first, input int last_msg);
    for (int i = first; i <= last_msg; i++) begin
      logic [15:0] e;
      e = ref_cw(src_img[SRC + 2*i], src_img[SRC + 2*i + 1]);
      check($sformatf("%s cw%0d", tag, i),
            {16'h0, dst_byte(DST + 2*i + 1), dst_byte(DST + 2*i)}, {16'h0, e});
    end
  endtask

  // Start a run with a req edge and wait (bounded) for ack; lat counts cycles after start.
  task automatic run_once(input bit hold_req, input bit glitch_mid, input bit edge_in_done,
                          output int lat);
    bit got;
    run_id++;
    @(negedge clock);
    req = 1'b1;
    #1 check("busy_in_start_cycle", busy, 1);
    lat = 0;
    got = 1'b0;
    while (lat < 2000 && !got) begin
      @(negedge clock);
      lat++;
      if (ack) got = 1'b1;
      if (!hold_req && lat == 1) req = 1'b0;
      if (glitch_mid && lat == 20) req = 1'b1;
      if (glitch_mid && lat == 21) req = 1'b0;
      if (got && edge_in_done) req = 1'b1;
    end
    check("ack_seen", got, 1);
    @(negedge clock);
    check("ack_one_cycle", ack, 0);
    check("busy_falls_with_ack", busy, 0);
  endtask

  task automatic quiet_window(input string tag);
    int a0, b0;
    a0 = n_ack;
    b0 = n_busy;
    repeat (100) @(negedge clock);
    check({tag, " no_ack"}, n_ack - a0, 0);
    check({tag, " no_busy"}, n_busy - b0, 0);
  endtask

  typedef struct {
    logic [7:0]  lo;
    logic [7:0]  hi;
    logic [15:0] cw;
  } vec_t;

  initial begin
    vec_t vt[5];
    int   lat, d0, w0, bw0, found;

    vt[0] = '{8'h00, 8'h00, 16'h0000};
    vt[1] = '{8'hFF, 8'h07, 16'hFFFF};
    vt[2] = '{8'h01, 8'h00, 16'h000F};
    vt[3] = '{8'h00, 8'h04, 16'h8117};
    vt[4] = '{8'hFF, 8'hFF, 16'hFFFF};

    reset = 1'b1;
    req   = 1'b0;
    repeat (3) @(negedge clock);
    #1;
    check("rst ack", ack, 0);
    check("rst busy", busy, 0);
    check("rst dm_req", dm_req, 0);
    check("rst mem_wr_en", mem_wr_en, 0);
    check("rst mem_addr", mem_addr, 0);
    check("rst mem_wr_data", mem_wr_data, 0);
    @(negedge clock);
    reset = 1'b0;

    // Directed table in msgs 0..4, random messages after.
    load_random();
    for (int i = 0; i < 5; i++) begin
      src_img[SRC + 2*i]     = vt[i].lo;
      src_img[SRC + 2*i + 1] = vt[i].hi;
    end
    w0 = n_wr;
    run_once(0, 0, 0, lat);
    check("table latency", lat, 76);
    check("table write count", n_wr - w0, 30);
    for (int i = 0; i < 5; i++)
      check($sformatf("table vec%0d", i),
            {16'h0, dst_byte(DST + 2*i + 1), dst_byte(DST + 2*i)}, {16'h0, vt[i].cw});
    verify_image("table_rand", 5, NUM_MSG - 1);

    // Fully random image, grant always high.
    load_random();
    run_once(0, 0, 0, lat);
    check("rand latency", lat, 76);
    verify_image("rand", 0, NUM_MSG - 1);

    // Same image with a 50% grant.
    gnt_random = 1'b1;
    d0  = n_denied;
    bw0 = n_badwr;
    w0  = n_wr;
    run_once(0, 0, 0, lat);
    check("stall latency", lat, 76 + (n_denied - d0));
    check("stall no write without gnt", n_badwr - bw0, 0);
    check("stall write count", n_wr - w0, 30);
    verify_image("stall", 0, NUM_MSG - 1);
    gnt_random = 1'b0;

    // Reset during WR_LO of msg 7.
    load_random();
    run_id++;
    @(negedge clock);
    req = 1'b1;
    @(negedge clock);
    req   = 1'b0;
    found = 0;
    for (int c = 0; c < 500 && found == 0; c++) begin
      if (dm_req && mem_wr_en && mem_addr == 8'(DST + 14)) found = 1;
      else @(negedge clock);
    end
    check("reached WR_LO msg7", found, 1);
    d0 = n_ack;
    #1 reset = 1'b1;
    #1;
    check("midrst ack", ack, 0);
    check("midrst busy", busy, 0);
    check("midrst dm_req", dm_req, 0);
    check("midrst mem_wr_en", mem_wr_en, 0);
    check("midrst mem_addr", mem_addr, 0);
    check("midrst mem_wr_data", mem_wr_data, 0);
    repeat (3) @(negedge clock);
    reset = 1'b0;
    quiet_window("after midrst");
    check("midrst no ack", n_ack - d0, 0);
    verify_image("midrst kept", 0, 6);
    check("midrst msg7 unwritten", (wr_gen[DST + 14] == run_id), 0);
    run_once(0, 0, 0, lat);
    check("rerun latency", lat, 76);
    verify_image("rerun", 0, NUM_MSG - 1);

    // req held high across the run: exactly one run.
    load_random();
    run_once(1, 0, 0, lat);
    check("hold latency", lat, 76);
    verify_image("hold", 0, NUM_MSG - 1);
    quiet_window("hold");
    req = 1'b0;
    @(negedge clock);

    // req pulse mid-run is ignored.
    run_once(0, 1, 0, lat);
    check("glitch latency", lat, 76);
    quiet_window("glitch");

    // req edge landing in the DONE cycle starts nothing.
    run_once(0, 0, 1, lat);
    check("done_edge latency", lat, 76);
    quiet_window("done_edge");
    req = 1'b0;
    @(negedge clock);

    // A fresh edge afterwards still works.
    load_random();
    run_once(0, 0, 0, lat);
    check("final latency", lat, 76);
    verify_image("final", 0, NUM_MSG - 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
